shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_pkg.sv | 29 ++
 rtl/shift_sequencer_if.sv | 27 ++
 rtl/shift_sequencer_usr.sv | 37 +++
 rtl/shift_sequencer.sv | 128 ++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer: command ops, FSM states, register modes.
// Pure declarations; no logic, no latency, no backpressure.
package shseq_pkg;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_ROTL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Command/status bundle between a command source (master) and the sequencer (slave).
// Valid/ready on the command side; status outputs are free-running.
interface shift_sequencer_if;
  import shseq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [CNT_W-1:0]  cmd_cnt;
  logic              ser_in;
  logic              ser_out;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_cnt, ser_in,
    input  cmd_ready, ser_out, busy, done, result
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_cnt, ser_in,
    output cmd_ready, ser_out, busy, done, result
  );

endinterface

// File: rtl/shift_sequencer_usr.sv
// 4-bit universal shift register: {s1,s0} 00 hold, 01 shift left, 10 shift right, 11 load.
// One-cycle update per clock; async active-high clear; no backpressure.
module universalShiftRegister
  import shseq_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              s1,
  input  logic              s0,
  input  logic              left_in,
  input  logic              right_in,
  input  logic [DATA_W-1:0] pa_in,
  output logic [DATA_W-1:0] pa_out,
  output logic              left_out,
  output logic              right_out
);

  logic [DATA_W-1:0] q;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q <= '0;
    end else begin
      case ({s1, s0})
        2'b01:   q <= {q[DATA_W-2:0], right_in};
        2'b10:   q <= {left_in, q[DATA_W-1:1]};
        2'b11:   q <= pa_in;
        default: q <= q;
      endcase
    end
  end

  assign pa_out    = q;
  assign left_out  = q[DATA_W-1];
  assign right_out = q[0];

endmodule

// File: rtl/shift_sequencer.sv
// Sequences LOAD/SHL/SHR/ROTL commands onto a universal shift register; done after 1, 2 or cnt+1 cycles.
// Accepts one command only in IDLE (no queuing); ROTL enabled by SHIFT_SEQUENCER_ROTATE_EN, else op 11 is a no-op.
module shift_sequencer
  import shseq_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  shift_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              fill_q;
  logic              accept;

  mode_e             mode;
  logic              left_in, right_in;
  logic              left_out, right_out;
  logic              ser_bit;
  logic [DATA_W-1:0] reg_q;

  assign accept = bus.cmd_valid && (state_q == ST_IDLE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command fields are captured at accept so the requester may change them while busy.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      op_q   <= OP_LOAD;
      data_q <= '0;
      cnt_q  <= '0;
      fill_q <= 1'b0;
    end else if (accept) begin
      op_q   <= op_e'(bus.cmd_op);
      data_q <= bus.cmd_data;
      cnt_q  <= bus.cmd_cnt;
      fill_q <= bus.ser_in;
    end else if (state_q == ST_SHIFT) begin
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op_e'(bus.cmd_op))
            OP_LOAD: state_d = ST_LOAD;
            OP_SHL,
            OP_SHR:  state_d = (bus.cmd_cnt == '0) ? ST_DONE : ST_SHIFT;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
            OP_ROTL: state_d = (bus.cmd_cnt == '0) ? ST_DONE : ST_SHIFT;
`else
            OP_ROTL: state_d = ST_DONE;
`endif
            default: state_d = ST_DONE;
          endcase
        end
      end
      ST_LOAD:  state_d = ST_DONE;
      ST_SHIFT: state_d = (cnt_q == 1) ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mode     = MODE_HOLD;
    left_in  = 1'b0;
    right_in = 1'b0;
    ser_bit  = 1'b0;
    case (state_q)
      ST_LOAD: mode = MODE_LOAD;
      ST_SHIFT: begin
        case (op_q)
          OP_SHL: begin
            mode     = MODE_SHL;
            right_in = fill_q;
            ser_bit  = left_out;
          end
          OP_SHR: begin
            mode     = MODE_SHR;
            left_in  = fill_q;
            ser_bit  = right_out;
          end
`ifdef SHIFT_SEQUENCER_ROTATE_EN
          OP_ROTL: begin
            mode     = MODE_SHL;
            right_in = left_out;
            ser_bit  = left_out;
          end
`endif
          default: mode = MODE_HOLD;
        endcase
      end
      default: mode = MODE_HOLD;
    endcase
  end

  universalShiftRegister u_usr (
    .clk       (clk),
    .clear     (clr),
    .s1        (mode[1]),
    .s0        (mode[0]),
    .left_in   (left_in),
    .right_in  (right_in),
    .pa_in     (data_q),
    .pa_out    (reg_q),
    .left_out  (left_out),
    .right_out (right_out)
  );

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.ser_out   = ser_bit;
  assign bus.result    = reg_q;

endmodule
